// File: rtl/window_3x3_linebuffer.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window feeding the edge-detection MAC.
// Optional build macro WINDOW_EOF_FLAG_EN adds the outEndOfFrame strobe for the last window of each frame.
module window_3x3_linebuffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   inPixel,
    input  logic                    inPixelValid,
    output logic [9*DATA_WIDTH-1:0] outPixel,
    output logic                    outPixelValid
`ifdef WINDOW_EOF_FLAG_EN
    ,
    output logic                    outEndOfFrame
`endif
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST_VALID = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST_VALID = ROW_W'(2);

    logic                  accept;
    logic [COL_W-1:0]      col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
    logic                  valid_q, valid_d;
    logic                  last_col, last_row;

    // lineA holds line y-1, lineB holds line y-2; neither is reset.
    logic [DATA_WIDTH-1:0] line_a_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] line_b_q [IMG_WIDTH];

    // New window column, index 0 = oldest line (top), 2 = current line (bottom).
    logic [DATA_WIDTH-1:0] new_col [3];

    assign accept   = inPixelValid;
    assign last_col = (col_cnt_q == COL_LAST);
    assign last_row = (row_cnt_q == ROW_LAST);

    assign new_col[0] = line_b_q[col_cnt_q];
    assign new_col[1] = line_a_q[col_cnt_q];
    assign new_col[2] = inPixel;

    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (accept) begin
            if (last_col) begin
                col_cnt_d = '0;
                row_cnt_d = last_row ? '0 : row_cnt_q + ROW_W'(1);
            end else begin
                col_cnt_d = col_cnt_q + COL_W'(1);
            end
        end
    end

    always_comb begin
        valid_d = accept && (row_cnt_q >= ROW_FIRST_VALID) && (col_cnt_q >= COL_FIRST_VALID);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            line_b_q[col_cnt_q] <= line_a_q[col_cnt_q];
            line_a_q[col_cnt_q] <= inPixel;
        end
    end

    // One shift row per window line; column 2 takes the newly read pixel of that line.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            logic [DATA_WIDTH-1:0] row_q [3];
            logic [DATA_WIDTH-1:0] row_d [3];

            always_comb begin
                row_d[0] = row_q[0];
                row_d[1] = row_q[1];
                row_d[2] = row_q[2];
                if (accept) begin
                    row_d[0] = row_q[1];
                    row_d[1] = row_q[2];
                    row_d[2] = new_col[gi];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    row_q[0] <= '0;
                    row_q[1] <= '0;
                    row_q[2] <= '0;
                end else begin
                    row_q[0] <= row_d[0];
                    row_q[1] <= row_d[1];
                    row_q[2] <= row_d[2];
                end
            end

            assign outPixel[3*gi*DATA_WIDTH +: 3*DATA_WIDTH] = {row_q[2], row_q[1], row_q[0]};
        end
    endgenerate

    assign outPixelValid = valid_q;

`ifdef WINDOW_EOF_FLAG_EN
    logic eof_q, eof_d;

    always_comb begin
        eof_d = valid_d && last_row && last_col;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eof_q <= 1'b0;
        end else begin
            eof_q <= eof_d;
        end
    end

    assign outEndOfFrame = eof_q;
`endif

endmodule
